// File: rtl/cpu_wb_arbiter.sv
// rtl/cpu_wb_arbiter.sv - Wishbone arbiter merging CPU ibus/dbus onto one master port with bus watchdog
module cpu_wb_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RR_MODE        = 0
) (
    input  logic                clk,
    input  logic                rst,
    // instruction bus (read-only master)
    input  logic [ADDR_W-1:0]   ibus_adr,
    input  logic                ibus_cyc,
    input  logic                ibus_stb,
    output logic [DATA_W-1:0]   ibus_dat_r,
    output logic                ibus_ack,
    output logic                ibus_err,
    // data bus master
    input  logic [ADDR_W-1:0]   dbus_adr,
    input  logic [DATA_W-1:0]   dbus_dat_w,
    input  logic [DATA_W/8-1:0] dbus_sel,
    input  logic                dbus_we,
    input  logic                dbus_cyc,
    input  logic                dbus_stb,
    output logic [DATA_W-1:0]   dbus_dat_r,
    output logic                dbus_ack,
    output logic                dbus_err,
    // shared interconnect master port
    output logic [ADDR_W-1:0]   wbm_adr,
    output logic [DATA_W-1:0]   wbm_dat_w,
    output logic [DATA_W/8-1:0] wbm_sel,
    output logic                wbm_we,
    output logic                wbm_cyc,
    output logic                wbm_stb,
    input  logic [DATA_W-1:0]   wbm_dat_r,
    input  logic                wbm_ack,
    input  logic                wbm_err,
    // status
    output logic                grant_dbus,
    output logic                timeout_pulse,
    output logic [ADDR_W-1:0]   timeout_addr
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_last_dbus;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [ADDR_W-1:0]  r_taddr;

    logic               w_req_i;
    logic               w_req_d;
    logic               w_arb_valid;
    logic               w_arb_dbus;
    logic               w_gnt_i;
    logic               w_gnt_d;
    logic               w_own_cyc;
    logic               w_own_stb;
    logic               w_term;
    logic               w_timeout;

    assign w_req_i = ibus_cyc & ibus_stb;
    assign w_req_d = dbus_cyc & dbus_stb;
    assign w_term  = wbm_ack | wbm_err;

    // Grants are masked during reset so a late slave response never leaks to a core.
    assign w_gnt_i = (r_state == GNT_I) && !rst;
    assign w_gnt_d = (r_state == GNT_D) && !rst;

    // Arbitration among the current requests; the tie rule depends on the priority mode.
    always_comb begin
        w_arb_valid = w_req_i | w_req_d;
        w_arb_dbus  = w_req_d;
        if (w_req_i && w_req_d) begin
            w_arb_dbus = (RR_MODE == 0) ? 1'b1 : !r_last_dbus;
        end
    end

    // Owner's own cycle/strobe and the watchdog trip; a slave ack/err in the same cycle wins.
    always_comb begin
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        if (w_gnt_i) begin
            w_own_cyc = ibus_cyc;
            w_own_stb = ibus_stb;
        end else if (w_gnt_d) begin
            w_own_cyc = dbus_cyc;
            w_own_stb = dbus_stb;
        end
        w_timeout = WD_EN && w_own_cyc && (r_cnt == TO_VAL) && !w_term;
    end

    // Bus multiplexing: owner drives the shared port, only the owner sees the response.
    always_comb begin
        wbm_adr    = '0;
        wbm_dat_w  = '0;
        wbm_sel    = '0;
        wbm_we     = 1'b0;
        wbm_cyc    = 1'b0;
        wbm_stb    = 1'b0;
        ibus_dat_r = '0;
        ibus_ack   = 1'b0;
        ibus_err   = 1'b0;
        dbus_dat_r = '0;
        dbus_ack   = 1'b0;
        dbus_err   = 1'b0;
        if (w_gnt_i) begin
            wbm_adr    = ibus_adr;
            wbm_sel    = '1;
            wbm_cyc    = ibus_cyc & !w_timeout;
            wbm_stb    = ibus_stb & !w_timeout;
            ibus_dat_r = wbm_dat_r;
            ibus_ack   = wbm_ack;
            ibus_err   = wbm_err | w_timeout;
        end else if (w_gnt_d) begin
            wbm_adr    = dbus_adr;
            wbm_dat_w  = dbus_dat_w;
            wbm_sel    = dbus_sel;
            wbm_we     = dbus_we;
            wbm_cyc    = dbus_cyc & !w_timeout;
            wbm_stb    = dbus_stb & !w_timeout;
            dbus_dat_r = wbm_dat_r;
            dbus_ack   = wbm_ack;
            dbus_err   = wbm_err | w_timeout;
        end
    end

    assign grant_dbus    = w_gnt_d;
    assign timeout_pulse = w_timeout;
    assign timeout_addr  = r_taddr;

    // Next-state and watchdog counter: hold while owner keeps cyc, hand over without a dead cycle.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (w_arb_valid) begin
                    w_next = w_arb_dbus ? GNT_D : GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (w_timeout) begin
                    w_next     = IDLE;
                    w_cnt_next = '0;
                end else if (w_own_cyc) begin
                    if (w_term) begin
                        w_cnt_next = '0;
                    end else if (w_own_stb) begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end else begin
                    w_cnt_next = '0;
                    if (w_arb_valid) begin
                        w_next = w_arb_dbus ? GNT_D : GNT_I;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: begin
                w_next     = IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    // State, last owner, watchdog count and captured fault address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last_dbus <= 1'b0;
            r_cnt       <= '0;
            r_taddr     <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_next == GNT_D) begin
                r_last_dbus <= 1'b1;
            end else if (w_next == GNT_I) begin
                r_last_dbus <= 1'b0;
            end
            if (w_timeout) begin
                r_taddr <= wbm_adr;
            end
        end
    end

endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// tb/tb_cpu_wb_arbiter.sv - self-checking bench for cpu_wb_arbiter in fixed and round-robin modes
module tb_cpu_wb_arbiter;

    localparam int TMO   = 8;
    localparam int OWN_N = 0;
    localparam int OWN_I = 1;
    localparam int OWN_D = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] i_adr, d_adr, d_dat_w, s_dat_r;
    logic [3:0]  d_sel;
    logic        i_cyc, i_stb, d_we, d_cyc, d_stb, s_ack, s_err;

    logic [1:0][31:0] idat, ddat, mb_adr, mb_dat, taddr;
    logic [1:0][3:0]  mb_sel;
    logic [1:0]       iack, ierr, dack, derr, mb_we, mb_cyc, mb_stb, gnt, pulse;

    int n_chk = 0;
    int n_err = 0;
    bit model_on = 1'b0;

    int          m_own   [2] = '{OWN_N, OWN_N};
    int          m_last  [2] = '{OWN_I, OWN_I};
    int          m_cnt   [2] = '{0, 0};
    logic [31:0] m_taddr [2] = '{32'h0, 32'h0};

    cpu_wb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO), .RR_MODE(0)) u_fixed (
        .clk(clk), .rst(rst),
        .ibus_adr(i_adr), .ibus_cyc(i_cyc), .ibus_stb(i_stb),
        .ibus_dat_r(idat[0]), .ibus_ack(iack[0]), .ibus_err(ierr[0]),
        .dbus_adr(d_adr), .dbus_dat_w(d_dat_w), .dbus_sel(d_sel), .dbus_we(d_we),
        .dbus_cyc(d_cyc), .dbus_stb(d_stb),
        .dbus_dat_r(ddat[0]), .dbus_ack(dack[0]), .dbus_err(derr[0]),
        .wbm_adr(mb_adr[0]), .wbm_dat_w(mb_dat[0]), .wbm_sel(mb_sel[0]), .wbm_we(mb_we[0]),
        .wbm_cyc(mb_cyc[0]), .wbm_stb(mb_stb[0]),
        .wbm_dat_r(s_dat_r), .wbm_ack(s_ack), .wbm_err(s_err),
        .grant_dbus(gnt[0]), .timeout_pulse(pulse[0]), .timeout_addr(taddr[0])
    );

    cpu_wb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst),
        .ibus_adr(i_adr), .ibus_cyc(i_cyc), .ibus_stb(i_stb),
        .ibus_dat_r(idat[1]), .ibus_ack(iack[1]), .ibus_err(ierr[1]),
        .dbus_adr(d_adr), .dbus_dat_w(d_dat_w), .dbus_sel(d_sel), .dbus_we(d_we),
        .dbus_cyc(d_cyc), .dbus_stb(d_stb),
        .dbus_dat_r(ddat[1]), .dbus_ack(dack[1]), .dbus_err(derr[1]),
        .wbm_adr(mb_adr[1]), .wbm_dat_w(mb_dat[1]), .wbm_sel(mb_sel[1]), .wbm_we(mb_we[1]),
        .wbm_cyc(mb_cyc[1]), .wbm_stb(mb_stb[1]),
        .wbm_dat_r(s_dat_r), .wbm_ack(s_ack), .wbm_err(s_err),
        .grant_dbus(gnt[1]), .timeout_pulse(pulse[1]), .timeout_addr(taddr[1])
    );

    task automatic chk(input string tag, input int m, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, m, obs, exp);
        end
    endtask

    // Reference model: who owns the bus, how long the owner has stalled, and the arbitration rules.
    always @(negedge clk) begin
        if (model_on) begin
            for (int m = 0; m < 2; m++) begin
                logic        ri, rd, oc, os, to, term;
                int          win;
                logic [70:0] e_w;
                logic [33:0] e_i, e_d;
                ri   = i_cyc & i_stb;
                rd   = d_cyc & d_stb;
                term = s_ack | s_err;
                if (ri && rd) win = (m == 0 || m_last[m] == OWN_I) ? OWN_D : OWN_I;
                else if (rd)  win = OWN_D;
                else if (ri)  win = OWN_I;
                else          win = OWN_N;
                oc = 1'b0; os = 1'b0;
                if (!rst && m_own[m] == OWN_I) begin oc = i_cyc; os = i_stb; end
                if (!rst && m_own[m] == OWN_D) begin oc = d_cyc; os = d_stb; end
                to  = oc && (m_cnt[m] == TMO) && !term;
                e_w = '0; e_i = '0; e_d = '0;
                if (!rst && m_own[m] == OWN_I) begin
                    e_w = {i_adr, 32'h0, 4'hf, 1'b0, i_cyc & !to, i_stb & !to};
                    e_i = {s_ack, s_err | to, s_dat_r};
                end
                if (!rst && m_own[m] == OWN_D) begin
                    e_w = {d_adr, d_dat_w, d_sel, d_we, d_cyc & !to, d_stb & !to};
                    e_d = {s_ack, s_err | to, s_dat_r};
                end
                chk("wbm", m, {mb_adr[m], mb_dat[m], mb_sel[m], mb_we[m], mb_cyc[m], mb_stb[m]}, e_w);
                chk("ibus", m, {iack[m], ierr[m], idat[m]}, e_i);
                chk("dbus", m, {dack[m], derr[m], ddat[m]}, e_d);
                chk("ctl", m, {gnt[m], pulse[m], taddr[m]},
                    {(!rst && m_own[m] == OWN_D), to, m_taddr[m]});
                if (rst) begin
                    m_own[m] = OWN_N; m_last[m] = OWN_I; m_cnt[m] = 0; m_taddr[m] = 32'h0;
                end else if (m_own[m] == OWN_N) begin
                    m_own[m] = win; m_cnt[m] = 0;
                end else if (to) begin
                    m_taddr[m] = (m_own[m] == OWN_I) ? i_adr : d_adr;
                    m_own[m] = OWN_N; m_cnt[m] = 0;
                end else if (oc) begin
                    m_cnt[m] = term ? 0 : m_cnt[m] + (os ? 1 : 0);
                end else begin
                    m_own[m] = win; m_cnt[m] = 0;
                end
                if (m_own[m] != OWN_N) m_last[m] = m_own[m];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_cyc = 0; i_stb = 0; d_cyc = 0; d_stb = 0; d_we = 0; s_ack = 0; s_err = 0;
    endtask

    initial begin
        rst = 1; i_adr = 0; d_adr = 0; d_dat_w = 0; d_sel = 0; s_dat_r = 0;
        idle();
        tick();
        model_on = 1'b1;
        tick();
        rst = 0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("rst_wbm", m, {mb_cyc[m], mb_stb[m], mb_adr[m]}, 34'h0);
            chk("rst_ctl", m, {gnt[m], pulse[m], taddr[m], iack[m], dack[m]}, 36'h0);
        end

        // ibus alone: latency one cycle, slave acks two cycles after strobe
        tick();
        i_adr = 32'h100; i_cyc = 1; i_stb = 1;
        tick();
        #1;
        for (int m = 0; m < 2; m++) chk("lat_grant", m, {mb_cyc[m], mb_stb[m], mb_adr[m]}, {2'b11, 32'h100});
        tick();
        for (int m = 0; m < 2; m++) chk("lat_noack", m, iack[m], 1'b0);
        tick();
        s_ack = 1; s_dat_r = 32'hDEADBEEF;
        #1;
        for (int m = 0; m < 2; m++) chk("lat_ack", m, {iack[m], idat[m], dack[m]}, {1'b1, 32'hDEADBEEF, 1'b0});
        tick();
        idle();
        tick();

        // repeated ties: dbus first, then ibus straight after dbus drops
        for (int rep = 0; rep < 4; rep++) begin
            i_adr = 32'h1000 + rep; d_adr = 32'h2000 + rep;
            i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1;
            tick();
            #1;
            for (int m = 0; m < 2; m++) chk("tie_first_d", m, {gnt[m], mb_cyc[m]}, 2'b11);
            s_ack = 1;
            tick();
            s_ack = 0; d_cyc = 0; d_stb = 0;
            tick();
            #1;
            for (int m = 0; m < 2; m++) chk("tie_then_i", m, {gnt[m], mb_cyc[m], mb_adr[m]}, {2'b01, 32'h1000 + rep});
            s_ack = 1;
            tick();
            idle();
            tick();
        end

        // single dbus requester twice: no forced alternation
        for (int rep = 0; rep < 2; rep++) begin
            d_adr = 32'h3000; d_cyc = 1; d_stb = 1;
            tick();
            #1;
            for (int m = 0; m < 2; m++) chk("single_d", m, {gnt[m], mb_cyc[m]}, 2'b11);
            s_ack = 1;
            tick();
            idle();
            tick();
        end
        // tie after a dbus grant: fixed mode keeps dbus, round-robin gives ibus
        i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1;
        tick();
        #1;
        chk("rr_tie", 0, gnt[0], 1'b1);
        chk("rr_tie", 1, gnt[1], 1'b0);
        s_ack = 1;
        tick();
        idle();
        tick();
        tick();

        // dbus 4-beat burst holds the bus against a pending ibus request
        d_adr = 32'h5000; d_cyc = 1; d_stb = 1;
        tick();
        i_adr = 32'h6000; i_cyc = 1; i_stb = 1;
        for (int beat = 0; beat < 4; beat++) begin
            #1;
            for (int m = 0; m < 2; m++) chk("burst_hold", m, {gnt[m], mb_adr[m]}, {1'b1, 32'h5000});
            s_ack = 1;
            tick();
        end
        s_ack = 0; d_cyc = 0; d_stb = 0;
        tick();
        #1;
        for (int m = 0; m < 2; m++) chk("burst_handover", m, {gnt[m], mb_cyc[m], mb_adr[m]}, {2'b01, 32'h6000});
        s_ack = 1;
        tick();
        idle();
        tick();

        // watchdog: dbus write never acknowledged
        d_adr = 32'h4000_0010; d_dat_w = 32'hCAFE0001; d_sel = 4'hf; d_we = 1; d_cyc = 1; d_stb = 1;
        tick();
        for (int k = 0; k < TMO; k++) begin
            #1;
            for (int m = 0; m < 2; m++) chk("to_wait", m, {pulse[m], derr[m], mb_cyc[m]}, 3'b001);
            tick();
        end
        #1;
        for (int m = 0; m < 2; m++) chk("to_fire", m, {pulse[m], derr[m], mb_cyc[m], mb_stb[m]}, 4'b1100);
        tick();
        d_cyc = 0; d_stb = 0; d_we = 0;
        #1;
        for (int m = 0; m < 2; m++) chk("to_addr", m, taddr[m], 32'h4000_0010);
        i_adr = 32'h104; i_cyc = 1; i_stb = 1;
        tick();
        s_ack = 1; s_dat_r = 32'h12345678;
        #1;
        for (int m = 0; m < 2; m++) chk("to_after_ibus", m, {mb_adr[m], iack[m], idat[m]}, {32'h104, 1'b1, 32'h12345678});
        tick();
        idle();
        tick();

        // reset in the middle of an ibus transfer with a late slave ack
        i_adr = 32'h200; i_cyc = 1; i_stb = 1;
        tick();
        rst = 1; s_ack = 1; s_dat_r = 32'h5A5A5A5A;
        tick();
        rst = 0; i_cyc = 0; i_stb = 0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("rst_mid_wbm", m, {mb_cyc[m], mb_stb[m], mb_adr[m], mb_sel[m]}, 38'h0);
            chk("rst_mid_resp", m, {iack[m], ierr[m], idat[m], dack[m], ddat[m]}, 67'h0);
            chk("rst_mid_ctl", m, {gnt[m], pulse[m], taddr[m]}, 34'h0);
        end
        s_ack = 0;
        i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1;
        tick();
        #1;
        for (int m = 0; m < 2; m++) chk("rst_first_tie", m, {gnt[m], mb_cyc[m]}, 2'b11);
        s_ack = 1;
        tick();
        idle();
        tick();

        // random traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst = ($urandom_range(0, 99) == 0);
            if (!i_cyc) begin
                if ($urandom_range(0, 2) == 0) begin i_cyc = 1; i_adr = $urandom; end
            end else if ($urandom_range(0, 6) == 0) begin
                i_cyc = 0;
            end
            i_stb = i_cyc & ($urandom_range(0, 3) != 0);
            if (!d_cyc) begin
                if ($urandom_range(0, 2) == 0) begin
                    d_cyc = 1; d_adr = $urandom; d_dat_w = $urandom;
                    d_sel = 4'($urandom); d_we = 1'($urandom);
                end
            end else if ($urandom_range(0, 6) == 0) begin
                d_cyc = 0;
            end
            d_stb = d_cyc & ($urandom_range(0, 3) != 0);
            s_ack = ($urandom_range(0, 4) == 0);
            s_err = ($urandom_range(0, 19) == 0);
            s_dat_r = $urandom;
        end
        tick();
        rst = 0;
        idle();
        tick();
        model_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
